// File: rtl/bus_pkg.sv
// Shared types and helpers for the multiplexed bus address-capture block.
package bus_pkg;

  localparam int unsigned BUSW_DEF = 16;
  localparam int unsigned SELW_DEF = 2;
  localparam int unsigned MAX_NCH  = 8;

  typedef enum logic {IDLE, PHASE} state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set request strictly after ptr, wrapping; ptr itself is checked last.
  function automatic rr_pick_t rr_pick(input logic [MAX_NCH-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int unsigned        nch);
    rr_pick_t   r;
    logic [2:0] ci;
    r = '0;
    for (int unsigned k = 1; k <= MAX_NCH; k++) begin
      ci = 3'(({29'd0, ptr} + k) % nch);
      if (!r.valid && k <= nch && req[ci]) begin
        r.valid = 1'b1;
        r.idx   = ci;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker over NCH requests, starting after ptr_i.
module rr_arbiter import bus_pkg::*; #(
  parameter int unsigned NCH  = 2,
  parameter int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  logic [MAX_NCH-1:0] req_ext;
  logic [2:0]         ptr_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext          = '0;
    req_ext[NCH-1:0] = req_i;
    ptr_ext          = 3'(ptr_i);
    pick             = rr_pick(req_ext, ptr_ext, NCH);
    gnt_vld_o        = pick.valid;
    gnt_idx_o        = IDXW'(pick.idx);
  end

endmodule

// File: rtl/bus_addr_mux.sv
// Round-robin multiplexed-bus address capture for NCH requesters.
// Define BUSMUX_REQ_LATCH_EN to treat req as pulses latched into per-channel pending bits.
module bus_addr_mux import bus_pkg::*; #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned BUSW   = BUSW_DEF,
  parameter int unsigned SELW   = SELW_DEF,
  parameter int unsigned PHASES = 2,
  parameter int unsigned DELAY  = 1,
  parameter int unsigned IDXW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*SELW-1:0]    sel_base,
  input  logic [NCH-1:0]         req,
  output logic [SELW-1:0]        sel,
  input  logic [BUSW-1:0]        bus,
  output logic [PHASES*BUSW-1:0] addr,
  output logic [NCH-1:0]         ack,
  output logic [IDXW-1:0]        ack_ch
);

  localparam int unsigned PHW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int unsigned AW  = PHASES * BUSW;

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   stage_q, stage_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic [IDXW-1:0] ack_ch_q, ack_ch_d;
  logic [PHW-1:0]  phase_q, phase_d;
  logic [3:0]      ctr_q, ctr_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic [NCH-1:0]  elig;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_vld;
  logic [SELW-1:0] base_gnt, base_cur;

`ifdef BUSMUX_REQ_LATCH_EN
  logic [NCH-1:0] pend_q, pend_d, pend_clr;

  // A pulse landing on the same edge as the grant clear keeps the bit set.
  always_comb begin
    pend_clr = '0;
    if (state_q == IDLE && gnt_vld) pend_clr[gnt_idx] = 1'b1;
    pend_d = (pend_q & ~pend_clr) | req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign elig = pend_q;
`else
  // Masking the acked channel stops a still-held req from being regranted.
  assign elig = req & ~ack_q;
`endif

  rr_arbiter #(.NCH(NCH), .IDXW(IDXW)) u_arb (
    .req_i     (elig),
    .ptr_i     (ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign base_gnt = sel_base[gnt_idx*SELW +: SELW];
  assign base_cur = sel_base[ptr_q*SELW +: SELW];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    stage_d  = stage_q;
    ack_d    = '0;
    ack_ch_d = ack_ch_q;
    phase_d  = phase_q;
    ctr_d    = ctr_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          sel_d   = base_gnt;
          phase_d = '0;
          ctr_d   = 4'(DELAY);
          ptr_d   = gnt_idx;
          state_d = PHASE;
        end
      end
      PHASE: begin
        if (ctr_q != 4'd0) begin
          ctr_d = ctr_q - 4'd1;
        end else begin
          stage_d[phase_q*BUSW +: BUSW] = bus;
          if (phase_q != PHW'(PHASES - 1)) begin
            phase_d = phase_q + 1'b1;
            sel_d   = base_cur + SELW'(phase_q) + SELW'(1);
            ctr_d   = 4'(DELAY);
          end else begin
            // stage_d already holds the final slice straight from the bus.
            addr_d        = stage_d;
            ack_d[ptr_q]  = 1'b1;
            ack_ch_d      = ptr_q;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      addr_q   <= '0;
      ack_q    <= '0;
      ack_ch_q <= '0;
      phase_q  <= '0;
      ctr_q    <= '0;
      ptr_q    <= IDXW'(NCH - 1);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      ack_q    <= ack_d;
      ack_ch_q <= ack_ch_d;
      phase_q  <= phase_d;
      ctr_q    <= ctr_d;
      ptr_q    <= ptr_d;
    end
  end

  // Staging is pure datapath and is only ever read after being written.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign sel    = sel_q;
  assign addr   = addr_q;
  assign ack    = ack_q;
  assign ack_ch = ack_ch_q;

endmodule

// File: tb/tb_bus_addr_mux.sv
// Directed bench for bus_addr_mux: one DELAY=0 and one DELAY=1 instance.
module tb_bus_addr_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sel_base;
  logic [1:0]  req0, req1;
  logic [1:0]  sel0, sel1;
  logic [15:0] bus0, bus1;
  logic [31:0] addr0, addr1;
  logic [1:0]  ack0, ack1;
  logic [0:0]  ack_ch0, ack_ch1;
  logic        glitch1;
  int          n_chk;
  int          n_fail;

  bus_addr_mux #(.NCH(2), .BUSW(16), .SELW(2), .PHASES(2), .DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sel_base(sel_base), .req(req0), .sel(sel0),
    .bus(bus0), .addr(addr0), .ack(ack0), .ack_ch(ack_ch0)
  );

  bus_addr_mux #(.NCH(2), .BUSW(16), .SELW(2), .PHASES(2), .DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sel_base(sel_base), .req(req1), .sel(sel1),
    .bus(bus1), .addr(addr1), .ack(ack1), .ack_ch(ack_ch1)
  );

  // Bus device: each select code exposes a fixed word.
  function automatic logic [15:0] dev(input logic [1:0] s);
    case (s)
      2'd0:    return 16'h1234;
      2'd1:    return 16'h0005;
      2'd2:    return 16'hABCD;
      default: return 16'h00EF;
    endcase
  endfunction

  assign bus0 = dev(sel0);
  assign bus1 = glitch1 ? 16'hBAD0 : dev(sel1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit which, input string tag);
    int n;
    n = 0;
    while (((which ? ack1 : ack0) == 2'b00) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 64'((which ? ack1 : ack0) != 2'b00), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    sel_base = {2'd2, 2'd0};
    rst_n    = 1'b0;
    req0     = 2'b11;
    req1     = 2'b11;
    glitch1  = 1'b0;
    #12;
    chk("rst_sel0", sel0, 2'd0);
    chk("rst_ack0", ack0, 2'b00);
    chk("rst_addr0", addr0, 32'h0);
    chk("rst_ackch0", ack_ch0, 1'b0);
    chk("rst_sel1", sel1, 2'd0);
    chk("rst_ack1", ack1, 2'b00);
    chk("rst_addr1", addr1, 32'h0);
    tick();
    chk("rst_held_ack0", ack0, 2'b00);
    req1  = 2'b00;
    rst_n = 1'b1;

`ifdef BUSMUX_REQ_LATCH_EN
    req0 = 2'b01;
    tick();
    req0 = 2'b10;
    tick();
    req0 = 2'b00;
    wait_ack(1'b0, "lat_a");
    chk("lat_a_ack", ack0, 2'b01);
    chk("lat_a_addr", addr0, 32'h0005_1234);
    req0 = 2'b10;
    tick();
    req0 = 2'b00;
    wait_ack(1'b0, "lat_b");
    chk("lat_b_ack", ack0, 2'b10);
    chk("lat_b_addr", addr0, 32'h00EF_ABCD);
    tick();
    wait_ack(1'b0, "lat_c");
    chk("lat_c_ack", ack0, 2'b10);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lat_quiet", ack0, 2'b00);
    end
`else
    // Round robin on DELAY=0 with both channels held.
    for (int n = 0; n < 4; n++) begin
      logic [1:0] want;
      want = (n % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(1'b0, "rr");
      chk("rr_ack", ack0, want);
      chk("rr_ack_ch", ack_ch0, (n % 2 == 0) ? 1'b0 : 1'b1);
      chk("rr_addr", addr0, (n % 2 == 0) ? 32'h0005_1234 : 32'h00EF_ABCD);
      req0 = req0 & ~want;
      tick();
      chk("rr_no_dup", ack0, 2'b00);
      req0 = req0 | want;
    end
    // ch0 was granted on the last edge; dropping req must not abort it.
    req0 = 2'b00;
    wait_ack(1'b0, "drop");
    chk("drop_ack", ack0, 2'b01);
    tick();

    // DELAY=0 exact timing.
    req0 = 2'b01;
    tick();
    chk("d0_sel_a", sel0, 2'd0);
    chk("d0_noack_a", ack0, 2'b00);
    tick();
    chk("d0_sel_b", sel0, 2'd1);
    chk("d0_noack_b", ack0, 2'b00);
    tick();
    chk("d0_ack", ack0, 2'b01);
    chk("d0_addr", addr0, 32'h0005_1234);
    req0 = 2'b00;
    tick();
    chk("d0_ack_off", ack0, 2'b00);
    chk("d0_addr_hold", addr0, 32'h0005_1234);
    chk("d0_sel_hold", sel0, 2'd1);

    // DELAY=1 with garbage on the bus during settle cycles.
    glitch1 = 1'b1;
    req1    = 2'b01;
    tick();
    chk("d1_sel_a", sel1, 2'd0);
    chk("d1_noack_a", ack1, 2'b00);
    tick();
    glitch1 = 1'b0;
    chk("d1_noack_b", ack1, 2'b00);
    chk("d1_sel_b", sel1, 2'd0);
    tick();
    chk("d1_sel_c", sel1, 2'd1);
    chk("d1_noack_c", ack1, 2'b00);
    glitch1 = 1'b1;
    tick();
    glitch1 = 1'b0;
    chk("d1_noack_d", ack1, 2'b00);
    tick();
    chk("d1_ack", ack1, 2'b01);
    chk("d1_addr", addr1, 32'h0005_1234);
    chk("d1_ack_ch", ack_ch1, 1'b0);
    req1 = 2'b00;
    tick();
    chk("d1_ack_off", ack1, 2'b00);

    // Reset in the middle of a channel-1 transaction.
    req1 = 2'b10;
    tick();
    chk("mid_sel", sel1, 2'd2);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", sel1, 2'd0);
    chk("mid_rst_addr", addr1, 32'h0);
    chk("mid_rst_ack", ack1, 2'b00);
    chk("mid_rst_ackch", ack_ch1, 1'b0);
    chk("mid_rst_addr0", addr0, 32'h0);
    req1 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_ack", ack1, 2'b00);
    end
    rst_n = 1'b1;
    wait_ack(1'b1, "post");
    chk("post_ack_ch0", ack1, 2'b01);
    chk("post_addr_ch0", addr1, 32'h0005_1234);
    req1 = 2'b10;
    tick();
    wait_ack(1'b1, "post2");
    chk("post_ack_ch1", ack1, 2'b10);
    chk("post_addr_ch1", addr1, 32'h00EF_ABCD);
    chk("post_ackch_ch1", ack_ch1, 1'b1);
    req1 = 2'b00;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_addr_mux.md
Name: bus_addr_mux

Overview:
- Generalised successor to the multiplexed address-capture logic on the cartridge bus.
- Serves NCH requesters that share one BUSW-wide multiplexed bus and one SELW-wide select output.
- Per request it steps through PHASES select codes, waits DELAY settle cycles per phase, assembles a PHASES*BUSW address, and pulses a per-channel ack.
- Round-robin arbitration between channels; sits between the bus pins and the 68k/audio address consumers.

Parameters:
- NCH, 2, number of requesting channels (1..8)
- BUSW, 16, width of multiplexed bus input
- SELW, 2, width of select output
- PHASES, 2, bus phases per transaction (1..4)
- DELAY, 1, settle cycles after each select change before capture (0..15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel_base  in  NCH*SELW  static per-channel base select code; channel i uses slice i
- req  in  NCH  per-channel request
- sel  out  SELW  bus select lines
- bus  in  BUSW  multiplexed bus data
- addr  out  PHASES*BUSW  assembled address; phase k occupies bits [k*BUSW +: BUSW]
- ack  out  NCH  one-cycle one-hot completion pulse
- ack_ch  out  clog2(NCH) (min 1)  index of the channel being acked

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - state IDLE; sel=0, addr=0, ack=0, ack_ch=0, phase=0, ctr=0.
  - Round-robin pointer = NCH-1, so channel 0 has first priority.
- States: IDLE, PHASE.
- IDLE:
  - If any eligible request exists, grant the first requesting channel found scanning from pointer+1 upward with wrap.
  - On that edge: sel<=sel_base[g]; phase<=0; ctr<=DELAY; pointer<=g; state<=PHASE.
- PHASE, ctr!=0: decrement ctr; nothing else changes.
- PHASE, ctr==0:
  - Capture bus into staging slice[phase].
  - If phase<PHASES-1: phase++; sel<=sel_base[g]+phase+1 (mod 2^SELW); ctr<=DELAY.
  - If phase==PHASES-1: addr<=staging with the final slice taken directly from bus; ack[g]<=1; ack_ch<=g; state<=IDLE.
- Timing:
  - Grant at edge t0; phase k is captured at edge t0+(k+1)(DELAY+1).
  - ack is high in the cycle after edge t0+PHASES*(DELAY+1).
- addr changes only together with ack and is stable between acks.
- ack deasserts after one cycle.
- sel holds its last value while IDLE.
- Level mode (default):
  - req must be held until ack; dropping req mid-transaction does not abort, and ack still pulses.
  - The channel whose ack is high is ineligible during that cycle, so a held req yields no duplicate grant.
- Simultaneous requests: exactly one grant; the others wait, served in round-robin order.
- Reset mid-transaction: immediate return to reset values; no ack is issued.

Optional Feature:
- Macro: BUSMUX_REQ_LATCH_EN.
- Defined: req is a pulse input. Each channel has a pending bit, set by req and cleared on grant. Arbitration uses the pending bits. If a pulse arrives on the same edge as the clear, set wins.
- Undefined: level mode as above; no pending register.

Decomposition:
- Shared package bus_pkg:
  - state enum (IDLE, PHASE)
  - SELW/BUSW defaults
  - round-robin pick function (request vector, pointer -> index, valid)
- Optional sub-module rr_arbiter (NCH-wide request, pointer, grant index/valid); otherwise a single module.

Test Plan:
- Reset: hold rst_n=0 with req=2'b11 -> sel=0, ack=0, addr=0; after release, channel 0 is granted first.
- DELAY=0, PHASES=2, sel_base[0]=0: req[0] held; bus=16'h1234 while sel=0, 16'h0005 while sel=1 -> sel 0 then 1; addr=32'h0005_1234; ack=2'b01 on cycle t0+3.
- DELAY=1: same stimulus -> captures at t0+2 and t0+4; ack=2'b01 on cycle t0+5; bus glitch during settle cycles is ignored.
- Round robin: req=2'b11 held, each channel drops req on its ack -> acks in order ch0, ch1, ch0, ch1; ack_ch toggles; no back-to-back duplicate grant.
- Reset asserted mid-PHASE of channel 1 -> outputs return to reset values asynchronously; no ack; after release, channel 0 is served first.
- BUSMUX_REQ_LATCH_EN: one-cycle pulse on req[1] during a channel-0 transaction -> channel 1 is served after channel 0 with exactly one ack; a second pulse on the grant edge yields a second transaction.
